// File: rtl/alu_stim_sequencer.sv
// Stimulus sequencer for the ALU frequency-test harness: sweeps every operand
// for each select code, holding each vector HOLD cycles, with pause and done reporting.
//
// state | meaning
// IDLE  | waiting for start; operand/select/vec_count keep last values
// RUN   | issuing vectors (valid=1) or paused (valid=0); busy=1
// DONE  | one-cycle completion pulse; vec_count = NUM_OPS*2^N
module alu_stim_sequencer #(
    parameter int N       = 4,
    parameter int SEL_W   = 4,
    parameter int NUM_OPS = 10,
    parameter int HOLD    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    output logic [N-1:0]       operand,
    output logic [SEL_W-1:0]   select,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [N+SEL_W-1:0] vec_count
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_OPS - 1);
    localparam logic [HC_W-1:0]    HC_ONE    = HC_W'(1);
    localparam logic [N-1:0]       OP_ONE    = N'(1);
    localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
    localparam logic [N+SEL_W-1:0] VC_ONE    = (N + SEL_W)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [HC_W-1:0]    hold_cnt, hold_cnt_nx;
    logic [N-1:0]       operand_nx;
    logic [SEL_W-1:0]   select_nx;
    logic [N+SEL_W-1:0] vec_count_nx;
    logic               valid_nx, busy_nx, done_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            operand   <= '0;
            select    <= '0;
            vec_count <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            operand   <= operand_nx;
            select    <= select_nx;
            vec_count <= vec_count_nx;
            valid     <= valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        operand_nx   = operand;
        select_nx    = select;
        vec_count_nx = vec_count;
        valid_nx     = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = RUN;
                    hold_cnt_nx  = '0;
                    operand_nx   = '0;
                    select_nx    = '0;
                    vec_count_nx = '0;
                    valid_nx     = 1'b1;
                    busy_nx      = 1'b1;
                end
            end
            RUN: begin
                busy_nx = 1'b1;
                if (!pause) begin
                    valid_nx = 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_nx  = '0;
                        vec_count_nx = vec_count + VC_ONE;
                        if (&operand) begin
                            if (select == SEL_LAST) begin
                                // final vector keeps its operand/select through DONE and IDLE
                                state_nx = DONE;
                                valid_nx = 1'b0;
                                busy_nx  = 1'b0;
                                done_nx  = 1'b1;
                            end else begin
                                operand_nx = '0;
                                select_nx  = select + SEL_ONE;
                            end
                        end else begin
                            operand_nx = operand + OP_ONE;
                        end
                    end else begin
                        hold_cnt_nx = hold_cnt + HC_ONE;
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule
